ifid_instr_queue: RTL and testbench
===================================

Name: ifid_instr_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register.
- A DEPTH-entry FIFO of {instruction, PC+2} pairs sits between fetch and decode, with valid/ready handshakes on both sides.
- Supports flush (jump / branch-taken / external), decode-side freeze, and per-entry jump and branch target generation at the head.
- Lets fetch run ahead of decode stalls without losing instructions.

Parameters:
- DATA_W, 16, instruction and PC width.
- DEPTH, 4, queue entries; power of two, at least 2.
- OFF_W, 12, width of the instruction offset field used for jump/branch targets; OFF_W+1 < DATA_W.
- NOP_WORD, 0, value driven on out_instr when the queue is empty.

Ports:
- clk  in  1  rising-edge clock
- rest  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_instr  in  DATA_W  fetched instruction word
- in_pcplus2  in  DATA_W  PC+2 of the fetched instruction
- in_ready  out  1  queue can accept (count < DEPTH)
- out_valid  out  1  head entry valid (count > 0)
- out_ready  in  1  decode consumes head this cycle
- freeze  in  1  decode stall; blocks pop
- flush  in  1  discard all entries (jump, brTaken, or external flush)
- out_instr  out  DATA_W  head instruction, or NOP_WORD when empty
- out_pcplus2  out  DATA_W  head PC+2, or 0 when empty
- jump_addr  out  DATA_W  {out_pcplus2[DATA_W-1:OFF_W+1], out_instr[OFF_W-1:0], 1'b0}
- branch_addr  out  DATA_W  out_pcplus2 + (sign-extended out_instr[OFF_W-1:0] << 1), modulo 2^DATA_W
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rest low, asynchronous):
  - count=0, read and write pointers = 0.
  - out_valid=0, in_ready=1, out_instr=NOP_WORD, out_pcplus2=0.
  - Storage contents are don't-care.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~freeze & ~flush.
- Flush (highest priority):
  - On a clock edge with flush=1, pointers and count clear to 0.
  - Any same-cycle push or pop is ignored; the next cycle has out_valid=0 and in_ready=1.
- Push: writes mem[wptr], and wptr increments modulo DEPTH.
- Pop: rptr increments modulo DEPTH.
- Count update: count += push - pop.
- Full with simultaneous pop: in_ready is computed from registered count, so when count==DEPTH, in_ready=0 even if a pop occurs; no write-through.
- Empty with simultaneous push: no bypass. The entry becomes visible at the head one cycle after the push; fetch-to-decode latency is minimum 1 cycle.
- Freeze: head and all outputs hold stable; pushes continue until full.
- Head outputs are a combinational read of mem[rptr], masked to NOP_WORD/0 when empty.
- jump_addr and branch_addr are combinational from the head outputs.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; count disambiguates full from empty.
- Reset mid-operation: immediate clear regardless of the handshake in progress.
- Assertions:
  - No push when count==DEPTH.
  - No pop when count==0.

Test Plan:
- Reset, then push instr 16'h1234 / pcp2 16'h0002, out_ready=1 → next cycle out_valid=1, out_instr=16'h1234; branch_addr=16'h0002+(sext(12'h234)<<1)=16'h046A; jump_addr=16'h0468.
- Hold out_ready=0 and push 5 words with DEPTH=4 → in_ready drops after the 4th push; count=4; the 5th word is not accepted; then pop 4 times → order preserved and count returns to 0.
- Full queue with in_valid=1 and out_ready=1 in the same cycle → pop occurs, push blocked, count=3; next cycle push is accepted and count=4.
- Queue holding 3 entries, assert flush together with in_valid and out_ready → next cycle count=0, out_valid=0, out_instr=NOP_WORD, nothing written.
- freeze=1 with 2 entries while pushing 2 more → head unchanged, count=4; release freeze → head advances one per cycle.
- Negative offset: instr 16'h0FFE, pcp2 16'h0010 → branch_addr=16'h000C; deassert rest mid-stream → outputs go to reset values asynchronously.

Source files
------------

// File: rtl/ifid_instr_queue_if.sv
// rtl/ifid_instr_queue_if.sv - fetch/decode handshake bundle for the IF/ID instruction queue
//
// Groups everything between fetch, the queue and decode except clk/rest.
//   slave  : the queue itself (consumes fetch/decode controls, drives head and status)
//   master : the environment (fetch + decode side)
// Signals:
//   in_valid/in_instr/in_pcplus2/in_ready : fetch-side push handshake
//   out_valid/out_ready                   : decode-side pop handshake
//   freeze, flush                         : decode stall and pipeline flush
//   out_instr/out_pcplus2                 : head entry (NOP_WORD/0 when empty)
//   jump_addr/branch_addr                 : targets computed from the head entry
//   count                                 : current occupancy
interface ifid_instr_queue_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pcplus2;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              freeze;
    logic              flush;
    logic [DATA_W-1:0] out_instr;
    logic [DATA_W-1:0] out_pcplus2;
    logic [DATA_W-1:0] jump_addr;
    logic [DATA_W-1:0] branch_addr;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_instr, in_pcplus2, out_ready, freeze, flush,
        output in_ready, out_valid, out_instr, out_pcplus2,
               jump_addr, branch_addr, count
    );

    modport master (
        output in_valid, in_instr, in_pcplus2, out_ready, freeze, flush,
        input  in_ready, out_valid, out_instr, out_pcplus2,
               jump_addr, branch_addr, count
    );
endinterface

// File: rtl/ifid_instr_queue.sv
// rtl/ifid_instr_queue.sv - DEPTH-entry FIFO of {instruction, PC+2} between fetch and decode
//
// Replaces the single-entry IF/ID register so fetch can run ahead of decode
// stalls. Flush has priority over everything; freeze blocks pops only.
// Ports:
//   clk  : rising-edge clock
//   rest : asynchronous active-low reset
//   bus  : ifid_instr_queue_if.slave (push/pop handshakes, freeze, flush,
//          head entry, jump/branch targets, occupancy)
module ifid_instr_queue #(
    parameter int                 DATA_W   = 16,
    parameter int                 DEPTH    = 4,
    parameter int                 OFF_W    = 12,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rest,
    ifid_instr_queue_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [DATA_W-1:0] mem_pcp2  [DEPTH];

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;
    logic not_empty;
    logic not_full;

    // Status comes only from the registered count: a pop in the same cycle
    // does not open a slot for a push (no write-through), and a push into an
    // empty queue is not visible until the next cycle (no bypass).
    assign not_empty = (count_q != '0);
    assign not_full  = (count_q != FULL_CNT);

    assign push = bus.in_valid & not_full & ~bus.flush;
    assign pop  = not_empty & bus.out_ready & ~bus.freeze & ~bus.flush;

    // Storage needs no reset; emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= bus.in_instr;
            mem_pcp2[wptr]  <= bus.in_pcplus2;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tells full from empty.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        bus.in_ready  = not_full;
        bus.out_valid = not_empty;
        bus.count     = count_q;
        if (not_empty) begin
            bus.out_instr   = mem_instr[rptr];
            bus.out_pcplus2 = mem_pcp2[rptr];
        end else begin
            bus.out_instr   = NOP_WORD;
            bus.out_pcplus2 = '0;
        end
    end

    // Jump keeps the upper PC+2 bits and replaces the rest with the halfword offset.
    assign bus.jump_addr = {bus.out_pcplus2[DATA_W-1:OFF_W+1],
                            bus.out_instr[OFF_W-1:0], 1'b0};

    // Branch offset is signed and halfword-scaled; the sum wraps at DATA_W bits.
    assign bus.branch_addr = bus.out_pcplus2 +
                             {{(DATA_W-OFF_W-1){bus.out_instr[OFF_W-1]}},
                              bus.out_instr[OFF_W-1:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rest) begin
            assert (!(push && count_q == FULL_CNT));
            assert (!(pop && count_q == '0));
        end
    end
endmodule

// File: tb/tb_ifid_instr_queue.sv
// tb/tb_ifid_instr_queue.sv - self-checking bench for ifid_instr_queue
module tb_ifid_instr_queue;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic clk;
    logic rest;

    ifid_instr_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    ifid_instr_queue #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .OFF_W   (12),
        .NOP_WORD(16'h0000)
    ) dut (
        .clk (clk),
        .rest(rest),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard: {instr, pcplus2} of every accepted push, in order.
    logic [31:0] sb [$];
    int          mcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                          input logic ordy, input logic frz, input logic fl);
        bus.in_valid   = v;
        bus.in_instr   = ins;
        bus.in_pcplus2 = pc;
        bus.out_ready  = ordy;
        bus.freeze     = frz;
        bus.flush      = fl;
        #1;
    endtask

    // Compare the DUT status and head against the scoreboard model.
    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(mcount));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(mcount < DEPTH));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mcount > 0));
        if (mcount > 0) begin
            chk({tag, ".head"}, {bus.out_instr, bus.out_pcplus2}, sb[0]);
        end else begin
            chk({tag, ".head"}, {bus.out_instr, bus.out_pcplus2}, 32'h0);
        end
    endtask

    // Advance one clock, applying the handshake rules to the model.
    task automatic tick();
        logic mpush;
        logic mpop;
        mpush = bus.in_valid && (mcount < DEPTH) && !bus.flush;
        mpop  = (mcount > 0) && bus.out_ready && !bus.freeze && !bus.flush;
        if (bus.flush) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (mpop) begin
                void'(sb.pop_front());
                mcount--;
            end
            if (mpush) begin
                sb.push_back({bus.in_instr, bus.in_pcplus2});
                mcount++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic v, input logic [15:0] ins,
                        input logic [15:0] pc, input logic ordy, input logic frz,
                        input logic fl);
        set_in(v, ins, pc, ordy, frz, fl);
        check_state(tag);
        tick();
    endtask

    initial begin
        mcount = 0;
        rest   = 1'b0;
        set_in(0, 16'h0, 16'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("reset.count", 32'(bus.count), 32'd0);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset.out_instr", 32'(bus.out_instr), 32'h0);
        chk("reset.out_pcplus2", 32'(bus.out_pcplus2), 32'h0);
        @(negedge clk);
        rest = 1'b1;
        @(posedge clk);
        #1;

        // Single push, visible one cycle later, then target generation.
        step("first.push", 1, 16'h1234, 16'h0002, 1, 0, 0);
        set_in(0, 16'h0, 16'h0, 1, 0, 0);
        check_state("first.head");
        chk("first.out_instr", 32'(bus.out_instr), 32'h1234);
        chk("first.branch_addr", 32'(bus.branch_addr), 32'h046A);
        chk("first.jump_addr", 32'(bus.jump_addr), 32'h0468);
        tick();

        // Five pushes with decode blocked: the fifth is refused.
        for (int k = 0; k < 5; k++) begin
            step("fill", 1, 16'hA000 + 16'(k), 16'h0100 + 16'(2 * k), 0, 0, 0);
        end
        set_in(0, 16'h0, 16'h0, 0, 0, 0);
        chk("fill.count", 32'(bus.count), 32'd4);
        chk("fill.in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            set_in(0, 16'h0, 16'h0, 1, 0, 0);
            check_state("drain");
            chk("drain.order", 32'(bus.out_instr), 32'hA000 + 32'(k));
            tick();
        end
        chk("drain.count", 32'(bus.count), 32'd0);

        // Full queue with push and pop requested together: pop only.
        for (int k = 0; k < 4; k++) begin
            step("full.fill", 1, 16'hB000 + 16'(k), 16'h0200 + 16'(2 * k), 0, 0, 0);
        end
        step("full.pushpop", 1, 16'hB004, 16'h0208, 1, 0, 0);
        chk("full.after_pop", 32'(bus.count), 32'd3);
        step("full.refill", 1, 16'hB004, 16'h0208, 0, 0, 0);
        chk("full.after_refill", 32'(bus.count), 32'd4);
        step("full.pop1", 0, 16'h0, 16'h0, 1, 0, 0);

        // Flush with 3 entries while pushing and popping.
        step("flush", 1, 16'hC000, 16'h0300, 1, 0, 1);
        set_in(0, 16'h0, 16'h0, 0, 0, 0);
        check_state("flush.after");
        chk("flush.count", 32'(bus.count), 32'd0);
        chk("flush.out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush.out_instr", 32'(bus.out_instr), 32'h0);
        chk("flush.in_ready", 32'(bus.in_ready), 32'd1);

        // Freeze holds the head while fetch keeps filling.
        step("frz.push0", 1, 16'hD000, 16'h0400, 0, 0, 0);
        step("frz.push1", 1, 16'hD001, 16'h0402, 0, 0, 0);
        step("frz.push2", 1, 16'hD002, 16'h0404, 1, 1, 0);
        chk("frz.head2", 32'(bus.out_instr), 32'hD000);
        step("frz.push3", 1, 16'hD003, 16'h0406, 1, 1, 0);
        chk("frz.head3", 32'(bus.out_instr), 32'hD000);
        chk("frz.count", 32'(bus.count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            set_in(0, 16'h0, 16'h0, 1, 0, 0);
            check_state("frz.release");
            chk("frz.order", 32'(bus.out_instr), 32'hD000 + 32'(k));
            tick();
        end

        // Negative branch offset.
        step("neg.push", 1, 16'h0FFE, 16'h0010, 0, 0, 0);
        set_in(0, 16'h0, 16'h0, 0, 0, 0);
        check_state("neg.head");
        chk("neg.branch_addr", 32'(bus.branch_addr), 32'h000C);
        chk("neg.jump_addr", 32'(bus.jump_addr), 32'h1FFC);

        // Asynchronous reset in the middle of a cycle.
        step("async.push", 1, 16'hE000, 16'h0500, 0, 0, 0);
        set_in(1, 16'hE001, 16'h0502, 1, 0, 0);
        #2;
        rest = 1'b0;
        #1;
        chk("async.count", 32'(bus.count), 32'd0);
        chk("async.out_valid", 32'(bus.out_valid), 32'd0);
        chk("async.in_ready", 32'(bus.in_ready), 32'd1);
        chk("async.out_instr", 32'(bus.out_instr), 32'h0);
        chk("async.out_pcplus2", 32'(bus.out_pcplus2), 32'h0);
        sb.delete();
        mcount = 0;
        set_in(0, 16'h0, 16'h0, 0, 0, 0);
        @(negedge clk);
        rest = 1'b1;
        @(posedge clk);
        #1;
        step("post.push", 1, 16'hF00D, 16'h0600, 0, 0, 0);
        step("post.pop", 0, 16'h0, 16'h0, 1, 0, 0);
        set_in(0, 16'h0, 16'h0, 0, 0, 0);
        check_state("post.end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
